// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative unsigned MUL and DIVU.
// valid/ready on both sides; results and flags are registered and held until taken.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [3:0]       ALU_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SEQ  = 4'b1111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, prod, rem;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last, in_iter, accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign in_iter   = (ALU_ctrl == OP_MUL) || (ALU_ctrl == OP_DIVU);
  assign cnt_nxt   = cnt + 1'b1;
  assign last      = (cnt_nxt == CNT_W'(WIDTH));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = in_iter ? BUSY : DONE;
      BUSY: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the accepted operands.
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_o;

  assign sum  = {1'b0, A_in} + {1'b0, B_in};
  assign diff = {1'b0, A_in} - {1'b0, B_in};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    case (ALU_ctrl)
      OP_AND: sc_res = A_in & B_in;
      OP_OR:  sc_res = A_in | B_in;
      OP_NOR: sc_res = ~(A_in | B_in);
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_o   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (sum[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_o   = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (diff[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SLT: sc_res = ($signed(A_in) < $signed(B_in)) ? WIDTH'(1) : '0;
      OP_SEQ: sc_res = (A_in == B_in) ? WIDTH'(1) : '0;
      default: sc_res = '0;
    endcase
  end

  // One iteration step. MUL: a_r is the shifting multiplicand, b_r the shifting
  // multiplier. DIVU: a_r shifts dividend bits out and quotient bits in, b_r is fixed.
  logic             is_div, ge;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] a_nxt, b_nxt, prod_nxt, rem_nxt, fin;

  assign is_div = (op_r == OP_DIVU);
  assign rem_sh = {rem, a_r[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, b_r});

  always_comb begin
    prod_nxt = prod;
    rem_nxt  = rem;
    a_nxt    = a_r;
    b_nxt    = b_r;
    if (is_div) begin
      rem_nxt = ge ? WIDTH'(rem_sh - {1'b0, b_r}) : rem_sh[WIDTH-1:0];
      a_nxt   = {a_r[WIDTH-2:0], ge};
    end else begin
      prod_nxt = prod + (b_r[0] ? a_r : '0);
      a_nxt    = a_r << 1;
      b_nxt    = b_r >> 1;
    end
    fin = is_div ? ((b_r == '0) ? '1 : a_nxt) : prod_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      prod      <= '0;
      rem       <= '0;
      cnt       <= '0;
      ALU_out   <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r <= ALU_ctrl;
          a_r  <= A_in;
          b_r  <= B_in;
          prod <= '0;
          rem  <= '0;
          cnt  <= '0;
          if (!in_iter) begin
            ALU_out   <= sc_res;
            carry_out <= sc_c;
            overflow  <= sc_o;
            zero      <= (sc_res == '0);
          end
        end
        BUSY: begin
          cnt  <= cnt_nxt;
          a_r  <= a_nxt;
          b_r  <= b_nxt;
          prod <= prod_nxt;
          rem  <= rem_nxt;
          if (last) begin
            ALU_out   <= fin;
            zero      <= (fin == '0);
            carry_out <= 1'b0;
            overflow  <= is_div && (b_r == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, out_ready, v32, v8, sel;
  logic [31:0] a, b;
  logic [3:0]  op;

  logic        rdy32, val32, c32, z32, o32;
  logic [31:0] out32;
  logic        rdy8, val8, c8, z8, o8;
  logic [7:0]  out8;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32),
    .A_in(a), .B_in(b), .ALU_ctrl(op), .out_valid(val32), .out_ready(out_ready),
    .ALU_out(out32), .carry_out(c32), .zero(z32), .overflow(o32));

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
    .A_in(a[7:0]), .B_in(b[7:0]), .ALU_ctrl(op), .out_valid(val8), .out_ready(out_ready),
    .ALU_out(out8), .carry_out(c8), .zero(z8), .overflow(o8));

  // Observed view of whichever instance is under test.
  logic        r_rdy, r_val, r_c, r_z, r_o;
  logic [31:0] r_out;
  always_comb begin
    r_rdy = sel ? rdy8 : rdy32;
    r_val = sel ? val8 : val32;
    r_c   = sel ? c8   : c32;
    r_z   = sel ? z8   : z32;
    r_o   = sel ? o8   : o32;
    r_out = sel ? {24'h0, out8} : out32;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w8, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int k;
    sel = w8;
    @(negedge clk);
    k = 0;
    while (!r_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!r_rdy) chk("issue_wait", {31'h0, r_rdy}, 32'h1);
    op = o; a = x; b = y;
    if (w8) v8 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v8 = 1'b0; v32 = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  task automatic run(input string tag, input logic w8, input logic [3:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e_out, input logic e_c, input logic e_z,
                     input logic e_o, input int e_lat);
    int lat;
    logic busy_ok;
    issue(w8, o, x, y);
    lat = 1;
    busy_ok = 1'b1;
    while (!r_val && lat < 60) begin
      if (r_rdy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {31'h0, r_val}, 32'h1);
    chk({tag, "_lat"}, lat, e_lat);
    if (e_lat > 1) chk({tag, "_busy_rdy"}, {31'h0, busy_ok}, 32'h1);
    chk({tag, "_out"}, r_out, e_out);
    chk({tag, "_flags"}, {29'h0, r_c, r_z, r_o}, {29'h0, e_c, e_z, e_o});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, {30'h0, r_val, r_rdy}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; v32 = 1'b0; v8 = 1'b0; sel = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst32", {out32[3:0], val32, rdy32, c32, z32, o32}, 9'b0000_01000);
    chk("rst8",  {out8[3:0],  val8,  rdy8,  c8,  z8,  o8},  9'b0000_01000);

    //   tag        w8  op       A             B             out           c  z  o  lat
    run("add_ovf",  0, 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 1);
    run("add_cry",  0, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 1);
    run("sub_brw",  0, 4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, 0, 0, 1);
    run("sub_ovf",  0, 4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1, 1);
    run("seq",      0, 4'b1111, 32'd5,        32'd5,        32'd1,        0, 0, 0, 1);
    run("slt",      0, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0, 1);
    run("slt_n",    0, 4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,        0, 1, 0, 1);
    run("or",       0, 4'b0001, 32'hF0F0,     32'h0F00,     32'hFFF0,     0, 0, 0, 1);
    run("nor",      0, 4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 1);
    run("bad_op",   0, 4'b0011, 32'h1234,     32'h5678,     32'h0,        0, 1, 0, 1);
    run("mul",      0, 4'b1000, 32'd7,        32'd6,        32'd42,       0, 0, 0, 33);
    run("mul_wrap", 0, 4'b1000, 32'h10000,    32'h10000,    32'h0,        0, 1, 0, 33);
    run("mul_big",  0, 4'b1000, 32'h12345,    32'h1000,     32'h12345000, 0, 0, 0, 33);
    run("divu",     0, 4'b1001, 32'd100,      32'd7,        32'd14,       0, 0, 0, 33);
    run("divu_big", 0, 4'b1001, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 0, 0, 0, 33);
    run("divu_z",   0, 4'b1001, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 1, 33);

    // Backpressure, with a competing op presented that must not be taken.
    issue(1'b0, 4'b0000, 32'hF0F0, 32'hFF00);
    v32 = 1'b1; op = 4'b0001; a = 32'h1; b = 32'h2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out32, val32, rdy32}, {32'hF000, 1'b1, 1'b0});
      @(negedge clk);
    end
    v32 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", {30'h0, val32, rdy32}, 32'h1);
    chk("bp_keep", out32, 32'hF000);

    // Reset in the middle of a MUL, after a result with nonzero flags.
    run("divu_z2",  0, 4'b1001, 32'd9,        32'd0,        32'hFFFFFFFF, 0, 0, 1, 33);
    issue(1'b0, 4'b1000, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst", {out32, val32, rdy32, c32, z32, o32}, {32'h0, 5'b01000});
    reset = 1'b0;
    begin
      logic stale;
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (val32) stale = 1'b1;
        @(negedge clk);
      end
      chk("midrst_stale", {31'h0, stale}, 32'h0);
    end
    run("post_rst", 0, 4'b0010, 32'd2,        32'd3,        32'd5,        0, 0, 0, 1);

    // Narrow instance.
    run("w8_add",   1, 4'b0010, 32'h7F,       32'h01,       32'h80,       0, 0, 1, 1);
    run("w8_sub",   1, 4'b0110, 32'h10,       32'h20,       32'hF0,       1, 0, 0, 1);
    run("w8_mul",   1, 4'b1000, 32'd15,       32'd17,       32'd255,      0, 0, 0, 9);
    run("w8_mulw",  1, 4'b1000, 32'd16,       32'd16,       32'd0,        0, 1, 0, 9);
    run("w8_divu",  1, 4'b1001, 32'd200,      32'd3,        32'd66,       0, 0, 0, 9);
    run("w8_divz",  1, 4'b1001, 32'd7,        32'd0,        32'hFF,       0, 0, 1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
